// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button pulse bank.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_CHK = 3'd1,
    PULSE     = 3'd2,
    HELD      = 3'd3,
    REL_CHK   = 3'd4
  } btn_state_t;

  localparam int BTN_N_CH_DEF          = 4;
  localparam int BTN_SYNC_STAGES_DEF   = 2;
  localparam int BTN_DEBOUNCE_CYC_DEF  = 16;
  localparam int BTN_REPEAT_DELAY_DEF  = 500;
  localparam int BTN_REPEAT_PERIOD_DEF = 100;

  // Counter must hold the largest of the three window lengths.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One key channel: synchroniser chain, debounce FSM and window counter.
// Auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module btn_chan
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES   = BTN_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYC  = BTN_DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DELAY  = BTN_REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = BTN_REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic btn,
  output logic held
);

  localparam int CW = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   ks;
  btn_state_t             state;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_inc;

  assign ks      = sync[SYNC_STAGES-1];
  // Saturating increment: the counter parks at all-ones rather than wrapping.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

`ifdef BTN_REPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
  logic rep_run;  // 0: waiting out the initial delay, 1: periodic repeats
`endif

  // Synchroniser chain; resets to released (high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], key};
  end

  // Debounce FSM with registered pulse/level outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      btn   <= 1'b0;
      held  <= 1'b0;
`ifdef BTN_REPEAT_EN
      rep_run <= 1'b0;
`endif
    end else begin
      btn <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!ks) state <= PRESS_CHK;
        end
        PRESS_CHK: begin
          if (ks) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= PULSE;
            cnt   <= '0;
            btn   <= 1'b1;
            held  <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PULSE: begin
          state <= HELD;
          cnt   <= '0;
`ifdef BTN_REPEAT_EN
          rep_run <= 1'b0;
`endif
        end
        HELD: begin
          // Release check takes priority over any repeat due this cycle.
          if (ks) begin
            state <= REL_CHK;
            cnt   <= '0;
          end
`ifdef BTN_REPEAT_EN
          else if (cnt == (rep_run ? RP_LAST : RD_LAST)) begin
            btn     <= 1'b1;
            cnt     <= '0;
            rep_run <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
`endif
        end
        REL_CHK: begin
          if (!ks) begin
            state <= HELD;
            cnt   <= '0;
`ifdef BTN_REPEAT_EN
            rep_run <= 1'b0;
`endif
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            held  <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_pulse_bank.sv
// N-channel push-button front end: sync + debounce + press pulse per key.
// Optional auto-repeat while held: define BTN_REPEAT_EN.
module btn_pulse_bank
  import btn_pkg::*;
#(
  parameter int N_CH          = BTN_N_CH_DEF,
  parameter int SYNC_STAGES   = BTN_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYC  = BTN_DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DELAY  = BTN_REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = BTN_REPEAT_PERIOD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] key,
  output logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] held
);

  // Independent channels; no arbitration between keys.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk (clk),
      .rst (rst),
      .key (key[i]),
      .btn (btn[i]),
      .held(held[i])
    );
  end

endmodule

// File: tb/tb_btn_pulse_bank.sv
// Bench for btn_pulse_bank: expected pulses are queued with their cycle
// number when stimulus is driven, and a negedge monitor pops/compares them.
module tb_btn_pulse_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'hF;
  logic [3:0] btn;
  logic [3:0] held;

  btn_pulse_bank #(
    .N_CH         (4),
    .SYNC_STAGES  (2),
    .DEBOUNCE_CYC (4),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .key (key),
    .btn (btn),
    .held(held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } exp_t;
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Every nonzero btn must match the head of the scoreboard at that cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      checks++;
      if (btn !== sb[0].mask) begin
        failures++;
        $display("FAIL btn_pulse cyc=%0d got=%b exp=%b", cyc, btn, sb[0].mask);
      end
      void'(sb.pop_front());
    end else if (btn !== 4'b0000) begin
      checks++;
      failures++;
      $display("FAIL btn_unexpected cyc=%0d got=%b exp=0000", cyc, btn);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sb_done(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s missed_pulses got=%0d exp=0 (next cyc=%0d)", name, sb.size(), sb[0].cyc);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key = 4'hF;
    step(3);
    checks++;
    if (btn !== 4'b0 || held !== 4'b0) begin
      failures++;
      $display("FAIL reset_outputs btn=%b held=%b exp=0000/0000", btn, held);
    end
    rst = 1'b0;
    step(50);
    checks++;
    if (held !== 4'b0) begin
      failures++;
      $display("FAIL reset_idle_held got=%b exp=0000", held);
    end
    sb_done("reset_idle");
  endtask

  task automatic test_press();
    int c;
    c = cyc;
    key[0] = 1'b0;
    sb.push_back('{c + 7, 4'b0001});
    for (int k = 1; k <= 12; k++) begin
      step(1);
      checks++;
      if (held[0] !== (k >= 7)) begin
        failures++;
        $display("FAIL press_held edge=%0d got=%b exp=%b", k, held[0], (k >= 7));
      end
    end
    key[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      checks++;
      if (held[0] !== (k < 7)) begin
        failures++;
        $display("FAIL release_held edge=%0d got=%b exp=%b", k, held[0], (k < 7));
      end
    end
    step(10);
    sb_done("press");
  endtask

  task automatic test_glitch();
    key[1] = 1'b0;
    step(3);
    key[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      checks++;
      if (held[1] !== 1'b0) begin
        failures++;
        $display("FAIL glitch_held edge=%0d got=%b exp=0", k, held[1]);
      end
    end
    sb_done("glitch");
  endtask

  task automatic test_simultaneous();
    int c;
    c = cyc;
    key[3:2] = 2'b00;
    sb.push_back('{c + 7, 4'b1100});
    step(10);
    checks++;
    if (held[3:2] !== 2'b11) begin
      failures++;
      $display("FAIL simul_held got=%b exp=11", held[3:2]);
    end
    // Short release bounce while held: no new pulse, held stays up.
    key[3:2] = 2'b11;
    step(2);
    key[3:2] = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      checks++;
      if (held[3:2] !== 2'b11) begin
        failures++;
        $display("FAIL bounce_held edge=%0d got=%b exp=11", k, held[3:2]);
      end
    end
    key[3:2] = 2'b11;
    step(12);
    checks++;
    if (held !== 4'b0) begin
      failures++;
      $display("FAIL simul_release got=%b exp=0000", held);
    end
    sb_done("simultaneous");
  endtask

  task automatic test_reset_mid();
    int c;
    c = cyc;
    key[2] = 1'b0;
    sb.push_back('{c + 7, 4'b0100});
    step(12);
    key[0] = 1'b0;
    step(4);
    checks++;
    if (held !== 4'b0100) begin
      failures++;
      $display("FAIL pre_reset_held got=%b exp=0100", held);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (btn !== 4'b0 || held !== 4'b0) begin
      failures++;
      $display("FAIL async_clear btn=%b held=%b exp=0000/0000", btn, held);
    end
    step(2);
    rst = 1'b0;
    c = cyc;
    sb.push_back('{c + 7, 4'b0101});
    step(6);
    checks++;
    if (held !== 4'b0) begin
      failures++;
      $display("FAIL post_reset_early_held got=%b exp=0000", held);
    end
    step(1);
    checks++;
    if (held !== 4'b0101) begin
      failures++;
      $display("FAIL post_reset_held got=%b exp=0101", held);
    end
    step(5);
    key = 4'hF;
    step(12);
    sb_done("reset_mid");
  endtask

  task automatic test_repeat();
    int c;
    int f;
    c = cyc;
    f = c + 7;
    key[0] = 1'b0;
    sb.push_back('{f, 4'b0001});
`ifdef BTN_REPEAT_EN
    sb.push_back('{f + 21, 4'b0001});
    sb.push_back('{f + 29, 4'b0001});
    sb.push_back('{f + 37, 4'b0001});
    sb.push_back('{f + 45, 4'b0001});
    sb.push_back('{f + 53, 4'b0001});
`endif
    step(65);
    checks++;
    if (held[0] !== 1'b1) begin
      failures++;
      $display("FAIL repeat_held got=%b exp=1", held[0]);
    end
    key[0] = 1'b1;
    step(20);
    sb_done("repeat");
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
